// File: rtl/cpu_pkg.sv
// Shared IF-stage types: fetch FSM states, redirect sources, PC defaults.
// Redirect sources are encoded in ascending priority so they compare directly.
package cpu_pkg;

  typedef enum logic {
    IF_RUN  = 1'b0,
    IF_HOLD = 1'b1
  } if_state_e;

  typedef enum logic [1:0] {
    RD_NONE   = 2'd0,
    RD_BRANCH = 2'd1,
    RD_RET    = 2'd2,
    RD_TRAP   = 2'd3
  } redirect_src_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          PC_STEP_DEFAULT  = 4;

endpackage

// File: rtl/if_pc_unit_redirect_arb.sv
// Live redirect priority select: trap > return > branch.
// Purely combinational; the top owns all state.
module if_redirect_arb
  import cpu_pkg::*;
(
  input  logic          i_interrupt,
  input  logic [31:0]   i_trap_pc,
  input  logic          i_ret,
  input  logic [31:0]   i_ret_pc,
  input  logic          i_branch,
  input  logic [31:0]   i_branch_pc,
  output redirect_src_e o_src,
  output logic [31:0]   o_target
);

  always_comb begin
    o_src    = RD_NONE;
    o_target = 32'h0;
    priority case (1'b1)
      i_interrupt: begin
        o_src    = RD_TRAP;
        o_target = i_trap_pc;
      end
      i_ret: begin
        o_src    = RD_RET;
        o_target = i_ret_pc;
      end
      i_branch: begin
        o_src    = RD_BRANCH;
        o_target = i_branch_pc;
      end
      default: begin
        o_src    = RD_NONE;
        o_target = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/if_pc_unit.sv
// IF stage PC unit: next-PC arbitration, stall-time redirect latching, IF/ID flush.
// Optional IF_PC_MISALIGN_CHK_EN: flag and word-align misaligned redirect targets.
module if_pc_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        im_stall,
  input  logic        dm_stall,
  input  logic        CSR_stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        CSR_interrupt,
  input  logic [31:0] CSR_trap_pc,
  input  logic        CSR_ret,
  input  logic [31:0] CSR_ret_pc,
  input  logic [31:0] im_rdata,
  output logic [31:0] im_addr,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        IFID_flush,
  output logic        fetch_misaligned
);

  if_state_e     r_state;
  logic [31:0]   r_pc;
  logic          r_pend_valid;
  logic [31:0]   r_pend_pc;
  redirect_src_e r_pend_src;

  logic          w_stall;
  redirect_src_e w_live_src;
  logic [31:0]   w_live_tgt;
  logic          w_live;
  logic          w_live_wins;
  logic          w_apply;
  logic [31:0]   w_sel_tgt;
  logic [31:0]   w_load_tgt;

  if_redirect_arb u_arb (
    .i_interrupt (CSR_interrupt),
    .i_trap_pc   (CSR_trap_pc),
    .i_ret       (CSR_ret),
    .i_ret_pc    (CSR_ret_pc),
    .i_branch    (branch_taken),
    .i_branch_pc (branch_target),
    .o_src       (w_live_src),
    .o_target    (w_live_tgt)
  );

  assign w_stall     = ~pc_write | im_stall | dm_stall | CSR_stall;
  assign w_live      = (w_live_src != RD_NONE);
  // A newer redirect of equal or higher priority supersedes the latched one.
  assign w_live_wins = w_live & (w_live_src >= r_pend_src);
  assign w_sel_tgt   = (r_pend_valid & ~w_live_wins) ? r_pend_pc
                                                     : w_live_tgt;
  assign w_apply     = ~reset & ~w_stall
                     & (w_live | (r_state == IF_HOLD));

`ifdef IF_PC_MISALIGN_CHK_EN
  assign w_load_tgt       = {w_sel_tgt[31:2], 2'b00};
  assign fetch_misaligned = w_apply & (|w_sel_tgt[1:0]);
`else
  assign w_load_tgt       = w_sel_tgt;
  assign fetch_misaligned = 1'b0;
`endif

  assign IFID_flush  = w_apply;
  assign im_addr     = r_pc;
  assign pc          = r_pc;
  assign instruction = im_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IF_RUN;
      r_pc         <= RESET_PC;
      r_pend_valid <= 1'b0;
      r_pend_pc    <= 32'h0;
      r_pend_src   <= RD_NONE;
    end else begin
      unique case (r_state)
        IF_RUN: begin
          if (!w_stall) begin
            r_pc <= w_live ? w_load_tgt : r_pc + 32'(PC_STEP);
          end else if (w_live) begin
            r_pend_valid <= 1'b1;
            r_pend_pc    <= w_live_tgt;
            r_pend_src   <= w_live_src;
            r_state      <= IF_HOLD;
          end
        end
        IF_HOLD: begin
          if (!w_stall) begin
            r_pc         <= w_load_tgt;
            r_pend_valid <= 1'b0;
            r_pend_src   <= RD_NONE;
            r_state      <= IF_RUN;
          end else if (w_live_wins) begin
            r_pend_pc  <= w_live_tgt;
            r_pend_src <= w_live_src;
          end
        end
        default: r_state <= IF_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_if_pc_unit.sv
// Scoreboard bench for if_pc_unit: driver queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_if_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_write;
  logic        im_stall;
  logic        dm_stall;
  logic        CSR_stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        CSR_interrupt;
  logic [31:0] CSR_trap_pc;
  logic        CSR_ret;
  logic [31:0] CSR_ret_pc;
  logic [31:0] im_rdata;
  logic [31:0] im_addr;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        IFID_flush;
  logic        fetch_misaligned;

  typedef struct {
    string       nm;
    logic [31:0] a;
    logic        f;
    logic        m;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

`ifdef IF_PC_MISALIGN_CHK_EN
  localparam logic        MIS  = 1'b1;
  localparam logic [31:0] MA0  = 32'h0000_0100;
  localparam logic [31:0] MA1  = 32'h0000_0104;
`else
  localparam logic        MIS  = 1'b0;
  localparam logic [31:0] MA0  = 32'h0000_0102;
  localparam logic [31:0] MA1  = 32'h0000_0106;
`endif

  always #5 clk = ~clk;

  if_pc_unit dut (
    .clk              (clk),
    .reset            (reset),
    .pc_write         (pc_write),
    .im_stall         (im_stall),
    .dm_stall         (dm_stall),
    .CSR_stall        (CSR_stall),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .CSR_interrupt    (CSR_interrupt),
    .CSR_trap_pc      (CSR_trap_pc),
    .CSR_ret          (CSR_ret),
    .CSR_ret_pc       (CSR_ret_pc),
    .im_rdata         (im_rdata),
    .im_addr          (im_addr),
    .pc               (pc),
    .instruction      (instruction),
    .IFID_flush       (IFID_flush),
    .fetch_misaligned (fetch_misaligned)
  );

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_vec++;
      if (im_addr !== e.a || pc !== e.a || IFID_flush !== e.f
          || fetch_misaligned !== e.m || instruction !== im_rdata) begin
        n_err++;
        $display("FAIL %s: addr=%h pc=%h flush=%b mis=%b instr=%h, want addr=%h flush=%b mis=%b instr=%h",
                 e.nm, im_addr, pc, IFID_flush, fetch_misaligned,
                 instruction, e.a, e.f, e.m, im_rdata);
      end
    end
  end

  task automatic cyc(input string nm, input logic [31:0] a,
                     input logic f, input logic m);
    exp_t e;
    e.nm = nm;
    e.a  = a;
    e.f  = f;
    e.m  = m;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    pc_write      = 1'b1;
    im_stall      = 1'b0;
    dm_stall      = 1'b0;
    CSR_stall     = 1'b0;
    branch_taken  = 1'b0;
    CSR_interrupt = 1'b0;
    CSR_ret       = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, want summary");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    branch_target = 32'h0;
    CSR_trap_pc   = 32'h0;
    CSR_ret_pc    = 32'h0;
    im_rdata      = 32'h1234_5678;
    quiet();
    @(posedge clk);
    #1;

    // reset, with a branch that must not flush
    cyc("rst0", 32'h0, 1'b0, 1'b0);
    branch_taken = 1'b1; branch_target = 32'h40;
    cyc("rst1_br", 32'h0, 1'b0, 1'b0);
    quiet();
    cyc("rst2", 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    im_rdata = 32'hDEAD_BEEF;
    cyc("seq0", 32'h0, 1'b0, 1'b0);
    cyc("seq4", 32'h4, 1'b0, 1'b0);
    cyc("seq8", 32'h8, 1'b0, 1'b0);
    cyc("seqC", 32'hC, 1'b0, 1'b0);

    // unstalled branch
    branch_taken = 1'b1; branch_target = 32'h100;
    cyc("br_flush", 32'h10, 1'b1, 1'b0);
    quiet();
    cyc("br_tgt", 32'h100, 1'b0, 1'b0);
    cyc("br_next", 32'h104, 1'b0, 1'b0);

    // branch during im_stall, applied on release
    im_stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h200;
    cyc("stl_br", 32'h108, 1'b0, 1'b0);
    branch_taken = 1'b0;
    cyc("stl_h1", 32'h108, 1'b0, 1'b0);
    cyc("stl_h2", 32'h108, 1'b0, 1'b0);
    im_stall = 1'b0;
    cyc("stl_rel", 32'h108, 1'b1, 1'b0);
    cyc("stl_tgt", 32'h200, 1'b0, 1'b0);

    // pending branch overridden by trap; later mret ignored
    im_stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h300;
    cyc("pr_br", 32'h204, 1'b0, 1'b0);
    branch_taken = 1'b0; CSR_interrupt = 1'b1; CSR_trap_pc = 32'h800;
    cyc("pr_trap", 32'h204, 1'b0, 1'b0);
    CSR_interrupt = 1'b0; CSR_ret = 1'b1; CSR_ret_pc = 32'h900;
    cyc("pr_ret", 32'h204, 1'b0, 1'b0);
    im_stall = 1'b0;
    cyc("pr_rel", 32'h204, 1'b1, 1'b0);
    quiet();
    cyc("pr_tgt", 32'h800, 1'b0, 1'b0);

    // load-use hold, dm stall, CSR stall with mret
    pc_write = 1'b0;
    cyc("lu_hold", 32'h804, 1'b0, 1'b0);
    pc_write = 1'b1; dm_stall = 1'b1;
    cyc("dm_hold", 32'h804, 1'b0, 1'b0);
    dm_stall = 1'b0; CSR_stall = 1'b1;
    CSR_ret = 1'b1; CSR_ret_pc = 32'hA00;
    cyc("csr_ret", 32'h804, 1'b0, 1'b0);
    quiet();
    cyc("csr_rel", 32'h804, 1'b1, 1'b0);
    cyc("csr_tgt", 32'hA00, 1'b0, 1'b0);

    // pending branch, live trap at release wins
    im_stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h600;
    cyc("lv_br", 32'hA04, 1'b0, 1'b0);
    quiet();
    CSR_interrupt = 1'b1; CSR_trap_pc = 32'hC00;
    cyc("lv_rel", 32'hA04, 1'b1, 1'b0);
    quiet();
    cyc("lv_tgt", 32'hC00, 1'b0, 1'b0);

    // wrap at top of address space
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    cyc("wr_br", 32'hC04, 1'b1, 1'b0);
    quiet();
    cyc("wr_top", 32'hFFFF_FFFC, 1'b0, 1'b0);
    cyc("wr_zero", 32'h0, 1'b0, 1'b0);

    // reset while a redirect is pending
    im_stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h500;
    cyc("rh_br", 32'h4, 1'b0, 1'b0);
    quiet();
    reset = 1'b1;
    cyc("rh_rst", 32'h4, 1'b0, 1'b0);
    reset = 1'b0;
    cyc("rh_pc0", 32'h0, 1'b0, 1'b0);
    cyc("rh_pc4", 32'h4, 1'b0, 1'b0);

    // misaligned branch target
    branch_taken = 1'b1; branch_target = 32'h102;
    cyc("ma_br", 32'h8, 1'b1, MIS);
    quiet();
    cyc("ma_tgt", MA0, 1'b0, 1'b0);
    cyc("ma_next", MA1, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d left in queue, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
